kronos_bus_arbiter: RTL and testbench

Two-into-one memory bus arbiter for the Kronos core. It shares a single Wishbone-style memory port between the IF stage's instruction fetch and the WB stage's load/store requests. Grants are made by a small registered state machine, with data priority and alternation fairness, and each transaction is latched before being presented to memory. It sits between the core pipeline and the external memory/interconnect.

---
 rtl/kronos_bus_arbiter_pkg.sv | 36 +++
 rtl/kronos_arb_timer.sv | 45 ++++
 rtl/kronos_bus_arbiter.sv | 164 ++++++++++++++++
 tb/tb_kronos_bus_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kronos_bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// kronos_types
//
// Shared types for the Kronos memory bus arbiter.
//   arb_state_t : grant state of the arbiter (idle / fetch owns bus / data owns bus)
//   busreq_t    : one latched memory transaction as presented on the mem_* port
//   fetch_req() : builds the transaction for an instruction fetch (full-word read)
// ---------------------------------------------------------------------------
package kronos_types;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_FETCH,
        ARB_DATA
    } arb_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wr_data;
        logic [3:0]  mask;
        logic        wr_en;
    } busreq_t;

    localparam logic [3:0] FETCH_MASK = 4'hF;

    // Fetches are always full-word reads.
    function automatic busreq_t fetch_req(input logic [31:0] addr);
        busreq_t r;
        r.addr    = addr;
        r.wr_data = 32'h0;
        r.mask    = FETCH_MASK;
        r.wr_en   = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/kronos_arb_timer.sv
// ---------------------------------------------------------------------------
// kronos_arb_timer
//
// Counts how long the current grant has waited for mem_ack. Built only when
// KRONOS_ARB_TIMEOUT_EN is defined.
//
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clear     : a new grant is being made this cycle; restart the count
//   active    : arbiter is in a grant state
//   mem_ack   : memory completed this cycle
//   expired   : wait limit reached this cycle and mem_ack still absent
// ---------------------------------------------------------------------------
module kronos_arb_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic active,
    input  logic mem_ack,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;
    logic          at_limit;

    assign at_limit = (count == CW'(TIMEOUT));

    // The count saturates at the limit so it can never wrap back under it
    // while the arbiter is leaving the grant state.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (active && !mem_ack && !at_limit) begin
            count <= count + CW'(1);
        end
    end

    // A real mem_ack on the limit cycle takes precedence over the abort.
    assign expired = active && at_limit && !mem_ack;

endmodule

// File: rtl/kronos_bus_arbiter.sv
// ---------------------------------------------------------------------------
// kronos_bus_arbiter
//
// Shares one Wishbone-style memory port between instruction fetch (IF) and
// load/store (WB). Data wins ties; on completion the other side is granted
// directly if it is waiting, giving strict alternation under contention.
// The winning request is latched at grant time and driven from registers.
//
// Optional feature: define KRONOS_ARB_TIMEOUT_EN to abort a grant after
// TIMEOUT cycles without mem_ack (owner gets ack + err, rd_data = 0).
//
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   instr_addr/req            : fetch request (held until instr_ack)
//   instr_data/ack/err        : fetch response
//   data_addr/wr_data/mask/
//   data_wr_en/req            : load/store request (held until data_ack)
//   data_rd_data/ack/err      : load/store response
//   mem_addr/wr_data/mask/
//   mem_wr_en/req             : latched transaction to memory
//   mem_rd_data/ack           : memory response (ack is a one-cycle pulse)
// ---------------------------------------------------------------------------
module kronos_bus_arbiter
    import kronos_types::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] instr_addr,
    input  logic        instr_req,
    output logic [31:0] instr_data,
    output logic        instr_ack,
    output logic        instr_err,

    input  logic [31:0] data_addr,
    input  logic [31:0] data_wr_data,
    input  logic [3:0]  data_mask,
    input  logic        data_wr_en,
    input  logic        data_req,
    output logic [31:0] data_rd_data,
    output logic        data_ack,
    output logic        data_err,

    output logic [31:0] mem_addr,
    output logic [31:0] mem_wr_data,
    output logic [3:0]  mem_mask,
    output logic        mem_wr_en,
    output logic        mem_req,
    input  logic [31:0] mem_rd_data,
    input  logic        mem_ack
);

    arb_state_t state, state_nxt;
    busreq_t    bus_q, bus_nxt;
    busreq_t    data_bus;
    logic       load;
    logic       granted;
    logic       timeout_hit;
    logic       done;
    logic       fetch_owner;
    logic       data_owner;

    assign data_bus = '{addr:    data_addr,
                        wr_data: data_wr_data,
                        mask:    data_mask,
                        wr_en:   data_wr_en};

    assign granted = (state != ARB_IDLE);
    assign done    = mem_ack || timeout_hit;

`ifdef KRONOS_ARB_TIMEOUT_EN
    kronos_arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (load),
        .active  (granted),
        .mem_ack (mem_ack),
        .expired (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    // Next-state and grant selection. The side that just completed is not
    // looked at on its completion cycle, because its req is still high.
    always_comb begin
        state_nxt = state;
        bus_nxt   = bus_q;
        load      = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (data_req) begin
                    state_nxt = ARB_DATA;
                    bus_nxt   = data_bus;
                    load      = 1'b1;
                end else if (instr_req) begin
                    state_nxt = ARB_FETCH;
                    bus_nxt   = fetch_req(instr_addr);
                    load      = 1'b1;
                end
            end
            ARB_FETCH: begin
                if (done) begin
                    if (data_req) begin
                        state_nxt = ARB_DATA;
                        bus_nxt   = data_bus;
                        load      = 1'b1;
                    end else begin
                        state_nxt = ARB_IDLE;
                    end
                end
            end
            ARB_DATA: begin
                if (done) begin
                    if (instr_req) begin
                        state_nxt = ARB_FETCH;
                        bus_nxt   = fetch_req(instr_addr);
                        load      = 1'b1;
                    end else begin
                        state_nxt = ARB_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = ARB_IDLE;
            end
        endcase
    end

    // State and latched transaction register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB_IDLE;
            bus_q <= '0;
        end else begin
            state <= state_nxt;
            bus_q <= bus_nxt;
        end
    end

    assign mem_req     = granted;
    assign mem_addr    = bus_q.addr;
    assign mem_wr_data = bus_q.wr_data;
    assign mem_mask    = bus_q.mask;
    assign mem_wr_en   = bus_q.wr_en;

    // Acks are gated with rst so a mem_ack arriving during reset never
    // reaches a requester.
    assign fetch_owner = (state == ARB_FETCH) && !rst;
    assign data_owner  = (state == ARB_DATA)  && !rst;

    assign instr_ack = fetch_owner && done;
    assign data_ack  = data_owner  && done;
    assign instr_err = fetch_owner && timeout_hit;
    assign data_err  = data_owner  && timeout_hit;

    assign instr_data   = (fetch_owner && timeout_hit) ? 32'h0 : mem_rd_data;
    assign data_rd_data = (data_owner  && timeout_hit) ? 32'h0 : mem_rd_data;

endmodule

// File: tb/tb_kronos_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_kronos_bus_arbiter
//
// Directed bench for kronos_bus_arbiter. Expected requester responses are
// queued as stimulus is issued; a negedge monitor pops one entry per ack.
// Build with KRONOS_ARB_TIMEOUT_EN to exercise the abort path (TIMEOUT = 4).
// ---------------------------------------------------------------------------
module tb_kronos_bus_arbiter;

    logic        clk;
    logic        rst;
    logic [31:0] instr_addr;
    logic        instr_req;
    logic [31:0] instr_data;
    logic        instr_ack;
    logic        instr_err;
    logic [31:0] data_addr;
    logic [31:0] data_wr_data;
    logic [3:0]  data_mask;
    logic        data_wr_en;
    logic        data_req;
    logic [31:0] data_rd_data;
    logic        data_ack;
    logic        data_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic [3:0]  mem_mask;
    logic        mem_wr_en;
    logic        mem_req;
    logic [31:0] mem_rd_data;
    logic        mem_ack;

    int test_count = 0;
    int fail_count = 0;

    typedef struct {
        bit          is_data;
        logic [31:0] addr;
        logic [31:0] rd;
        bit          err;
    } exp_t;

    exp_t sb[$];

    kronos_bus_arbiter #(
        .TIMEOUT (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .instr_addr   (instr_addr),
        .instr_req    (instr_req),
        .instr_data   (instr_data),
        .instr_ack    (instr_ack),
        .instr_err    (instr_err),
        .data_addr    (data_addr),
        .data_wr_data (data_wr_data),
        .data_mask    (data_mask),
        .data_wr_en   (data_wr_en),
        .data_req     (data_req),
        .data_rd_data (data_rd_data),
        .data_ack     (data_ack),
        .data_err     (data_err),
        .mem_addr     (mem_addr),
        .mem_wr_data  (mem_wr_data),
        .mem_mask     (mem_mask),
        .mem_wr_en    (mem_wr_en),
        .mem_req      (mem_req),
        .mem_rd_data  (mem_rd_data),
        .mem_ack      (mem_ack)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop so the run can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        test_count++;
        if (act !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic ireq, input logic [31:0] iaddr,
                                 input logic dreq, input logic [31:0] daddr,
                                 input logic [31:0] wdata, input logic [3:0] mask,
                                 input logic wr);
        instr_req    = ireq;
        instr_addr   = iaddr;
        data_req     = dreq;
        data_addr    = daddr;
        data_wr_data = wdata;
        data_mask    = mask;
        data_wr_en   = wr;
    endtask

    task automatic memRespond(input logic ack, input logic [31:0] rd);
        mem_ack     = ack;
        mem_rd_data = rd;
    endtask

    task automatic pushExpect(input bit is_data, input logic [31:0] addr,
                              input logic [31:0] rd, input bit err);
        exp_t e;
        e.is_data = is_data;
        e.addr    = addr;
        e.rd      = rd;
        e.err     = err;
        sb.push_back(e);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every requester ack must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (instr_ack || data_ack) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected ack", 32'({instr_ack, data_ack}), 32'h0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("ack owner", 32'({instr_ack, data_ack}),
                                32'({!e.is_data, e.is_data}));
                    checkOutput("ack rd data", e.is_data ? data_rd_data : instr_data, e.rd);
                    checkOutput("ack err", 32'({instr_err, data_err}),
                                32'({!e.is_data && e.err, e.is_data && e.err}));
                    checkOutput("ack mem_addr", mem_addr, e.addr);
                end
            end else if (instr_err || data_err) begin
                checkOutput("err without ack", 32'({instr_err, data_err}), 32'h0);
            end
        end
    end

    initial begin
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        memRespond(0, 0);
        repeat (2) tick;

        // Reset state
        checkOutput("reset mem_req", 32'(mem_req), 0);
        checkOutput("reset mem_addr", mem_addr, 0);
        checkOutput("reset mem_wr_data", mem_wr_data, 0);
        checkOutput("reset mem_mask", 32'(mem_mask), 0);
        checkOutput("reset mem_wr_en", 32'(mem_wr_en), 0);
        checkOutput("reset acks/errs", 32'({instr_ack, data_ack, instr_err, data_err}), 0);
        rst = 1'b0;
        tick;

        // Lone fetch: grant cycles 1-2, ack in cycle 2
        applyStimulus(1, 32'h100, 0, 0, 0, 0, 0);
        tick;
        checkOutput("fetch c1 mem_req", 32'(mem_req), 1);
        checkOutput("fetch c1 mem_addr", mem_addr, 32'h100);
        checkOutput("fetch c1 mem_mask", 32'(mem_mask), 32'hF);
        checkOutput("fetch c1 mem_wr_en", 32'(mem_wr_en), 0);
        tick;
        checkOutput("fetch c2 mem_req", 32'(mem_req), 1);
        pushExpect(0, 32'h100, 32'h13, 0);
        memRespond(1, 32'h13);
        tick;
        checkOutput("fetch c3 mem_req", 32'(mem_req), 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        memRespond(0, 0);
        tick;

        // Tie: data store first, then fetch with no idle cycle
        applyStimulus(1, 32'h300, 1, 32'h2000, 32'hDEADBEEF, 4'h3, 1);
        tick;
        checkOutput("tie c1 mem_wr_en", 32'(mem_wr_en), 1);
        checkOutput("tie c1 mem_addr", mem_addr, 32'h2000);
        checkOutput("tie c1 mem_wr_data", mem_wr_data, 32'hDEADBEEF);
        checkOutput("tie c1 mem_mask", 32'(mem_mask), 32'h3);
        pushExpect(1, 32'h2000, 32'h55, 0);
        memRespond(1, 32'h55);
        tick;
        checkOutput("tie c2 mem_req", 32'(mem_req), 1);
        checkOutput("tie c2 mem_addr", mem_addr, 32'h300);
        checkOutput("tie c2 mem_mask", 32'(mem_mask), 32'hF);
        checkOutput("tie c2 mem_wr_en", 32'(mem_wr_en), 0);
        applyStimulus(1, 32'h300, 0, 0, 0, 0, 0);
        pushExpect(0, 32'h300, 32'hA5A5A5A5, 0);
        memRespond(1, 32'hA5A5A5A5);
        tick;
        checkOutput("tie c3 mem_req", 32'(mem_req), 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        memRespond(0, 0);
        tick;

        // Contention: both held, mem_ack every cycle (ignored while idle)
        applyStimulus(1, 32'h500, 1, 32'h400, 0, 4'hF, 0);
        memRespond(1, 32'hBAD);
        tick;
        for (int i = 0; i < 6; i++) begin
            bit d;
            d = (i % 2 == 0);
            checkOutput("contention grant", mem_addr, d ? 32'h400 : 32'h500);
            if (i == 5) applyStimulus(1, 32'h500, 0, 0, 0, 0, 0);
            pushExpect(d, d ? 32'h400 : 32'h500, 32'h1000 + 32'(i), 0);
            memRespond(1, 32'h1000 + 32'(i));
            tick;
        end
        checkOutput("contention end mem_req", 32'(mem_req), 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        memRespond(0, 0);
        tick;

        // Stability: requester fields change after grant
        applyStimulus(0, 0, 1, 32'h600, 0, 4'hF, 0);
        tick;
        applyStimulus(0, 0, 1, 32'h7777, 32'h1234, 4'h1, 1);
        tick;
        checkOutput("stable mem_addr", mem_addr, 32'h600);
        checkOutput("stable mem_wr_en", 32'(mem_wr_en), 0);
        checkOutput("stable mem_mask", 32'(mem_mask), 32'hF);
        checkOutput("stable mem_wr_data", mem_wr_data, 0);
        pushExpect(1, 32'h600, 32'hCAFE, 0);
        memRespond(1, 32'hCAFE);
        tick;
        checkOutput("stable end mem_req", 32'(mem_req), 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        memRespond(0, 0);
        tick;

        // Reset mid-grant, late mem_ack
        applyStimulus(1, 32'h800, 0, 0, 0, 0, 0);
        tick;
        checkOutput("rstmid c1 mem_req", 32'(mem_req), 1);
        tick;
        checkOutput("rstmid c2 mem_req", 32'(mem_req), 1);
        rst = 1'b1;
        tick;
        checkOutput("rstmid c3 mem_req", 32'(mem_req), 0);
        checkOutput("rstmid c3 mem_addr", mem_addr, 0);
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        memRespond(1, 32'h77);
        #2;
        checkOutput("rstmid c3 instr_ack", 32'(instr_ack), 0);
        tick;
        checkOutput("rstmid c4 mem_req", 32'(mem_req), 0);
        memRespond(0, 0);
        tick;

`ifdef KRONOS_ARB_TIMEOUT_EN
        // Timeout abort in the 5th granted cycle
        applyStimulus(0, 0, 1, 32'h900, 0, 4'hF, 0);
        tick;
        for (int k = 1; k <= 4; k++) begin
            checkOutput("timeout wait mem_req", 32'(mem_req), 1);
            checkOutput("timeout wait data_ack", 32'(data_ack), 0);
            tick;
        end
        checkOutput("timeout c5 mem_req", 32'(mem_req), 1);
        pushExpect(1, 32'h900, 32'h0, 1);
        memRespond(0, 32'hFFFFFFFF);
        tick;
        checkOutput("timeout c6 mem_req", 32'(mem_req), 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        memRespond(0, 0);
        tick;

        // mem_ack on the limit cycle is a normal completion
        applyStimulus(0, 0, 1, 32'hA00, 0, 4'hF, 0);
        repeat (5) tick;
        checkOutput("limit ack c5 mem_req", 32'(mem_req), 1);
        pushExpect(1, 32'hA00, 32'h4242, 0);
        memRespond(1, 32'h4242);
        tick;
        checkOutput("limit ack c6 mem_req", 32'(mem_req), 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        memRespond(0, 0);
        tick;
`else
        // Without the timeout a grant waits indefinitely
        applyStimulus(0, 0, 1, 32'hB00, 0, 4'hF, 0);
        tick;
        for (int k = 0; k < 40; k++) begin
            checkOutput("no-timeout hold mem_req", 32'(mem_req), 1);
            tick;
        end
        checkOutput("no-timeout mem_addr", mem_addr, 32'hB00);
        pushExpect(1, 32'hB00, 32'h99, 0);
        memRespond(1, 32'h99);
        tick;
        checkOutput("no-timeout end mem_req", 32'(mem_req), 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        memRespond(0, 0);
        tick;
`endif

        repeat (3) tick;
        checkOutput("scoreboard drained", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
